// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared constants, FSM state type and write-enable helper for the 256x59 SRAM controller.
package ct_spsram_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 59;

    localparam int unsigned GRP2_BIT = 58;
    localparam int unsigned GRP1_HI  = 57;
    localparam int unsigned GRP1_LO  = 29;
    localparam int unsigned GRP0_HI  = 28;
    localparam int unsigned GRP0_LO  = 0;

    typedef enum logic [1:0] {
        RESET,
        INIT,
        RUN
    } state_e;

    // Active-low bit write enables from the active-high 3-group mask.
    function automatic logic [DATA_WIDTH-1:0] wen_from_mask(input logic [2:0] mask);
        logic [DATA_WIDTH-1:0] w;
        w[GRP2_BIT]        = ~mask[2];
        w[GRP1_HI:GRP1_LO] = {(GRP1_HI - GRP1_LO + 1){~mask[1]}};
        w[GRP0_HI:GRP0_LO] = {(GRP0_HI - GRP0_LO + 1){~mask[0]}};
        return w;
    endfunction

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// Two-entry synchronous response FIFO; a pop frees the slot a same-cycle push uses when full.
module ct_spsram_rsp_fifo
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_cnt;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop && (r_cnt != 2'd0);
    assign w_push = push && ((r_cnt != 2'd2) || w_pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= push_data;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign vld   = (r_cnt != 2'd0);
    assign data  = vld ? r_mem[r_rp] : '0;
    assign count = r_cnt;

endmodule

// File: rtl/ct_spsram_256x59_ctrl.sv
// Request-stream to single-port SRAM pin controller with 2-entry read response buffer.
// Define CT_SPSRAM_CTRL_INIT_EN to zero-fill the array after every reset.
module ct_spsram_256x59_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 59,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);
    import ct_spsram_ctrl_pkg::*;

    state_e                r_state;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_a;
    logic [1:0]            w_count;
    logic [2:0]            w_used;
    logic                  w_credit;
    logic                  w_fire;
    logic                  w_rd_fire;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    logic [ADDR_WIDTH:0]   r_init_cnt;
    logic [ADDR_WIDTH:0]   w_init_nxt;

    assign w_init_nxt = r_init_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
`endif

    // In-flight read counts against the buffer so Q always has a slot.
    assign w_used    = {1'b0, w_count} + {2'b00, r_pend};
    assign w_credit  = 32'(w_used) < RSP_DEPTH;
    assign req_rdy   = (r_state == RUN) && (req_wr || w_credit);
    assign w_fire    = req_vld && req_rdy;
    assign w_rd_fire = w_fire && !req_wr;
    assign init_done = (r_state == RUN);

    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        D    = '0;
        A    = r_a;
`ifdef CT_SPSRAM_CTRL_INIT_EN
        if (r_state == INIT) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = r_init_cnt[ADDR_WIDTH-1:0];
        end else if (w_fire) begin
`else
        if (w_fire) begin
`endif
            CEN = 1'b0;
            A   = req_addr;
            if (req_wr) begin
                GWEN = 1'b0;
                WEN  = wen_from_mask(req_wmask);
                D    = req_wdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RESET;
            r_a     <= '0;
            r_pend  <= 1'b0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
            r_init_cnt <= '0;
`endif
        end else begin
            r_a    <= A;
            r_pend <= w_rd_fire;
            case (r_state)
`ifdef CT_SPSRAM_CTRL_INIT_EN
                RESET: r_state <= INIT;
                INIT: begin
                    r_init_cnt <= w_init_nxt;
                    if (w_init_nxt[ADDR_WIDTH]) begin
                        r_state <= RUN;
                    end
                end
`else
                RESET: r_state <= RUN;
`endif
                default: r_state <= RUN;
            endcase
        end
    end

    ct_spsram_rsp_fifo #(
        .WIDTH(DATA_WIDTH)
    ) u_rsp_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (r_pend),
        .push_data(Q),
        .pop      (rsp_rdy),
        .vld      (rsp_vld),
        .data     (rsp_rdata),
        .count    (w_count)
    );

endmodule

// File: tb/tb_ct_spsram_256x59_ctrl.sv
// Directed bench for ct_spsram_256x59_ctrl with a behavioural SRAM on the pins.
// Builds with or without CT_SPSRAM_CTRL_INIT_EN.
module tb_ct_spsram_256x59_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic        req_wr = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [58:0] req_wdata = '0;
    logic [2:0]  req_wmask = 3'd0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [58:0] rsp_rdata;
    logic        init_done;
    logic [7:0]  A;
    logic        CEN;
    logic        GWEN;
    logic [58:0] WEN;
    logic [58:0] D;
    logic [58:0] Q = '0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [58:0] mem [256];

    always #5 CLK = ~CLK;

    ct_spsram_256x59_ctrl u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .A        (A),
        .CEN      (CEN),
        .GWEN     (GWEN),
        .WEN      (WEN),
        .D        (D),
        .Q        (Q)
    );

    // Single-port SRAM model: per-bit active-low write enable, Q one cycle after read.
    always @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            else       Q <= mem[A];
        end
    end

    typedef struct {
        logic        vld;
        logic        wr;
        logic [7:0]  addr;
        logic [58:0] wdata;
        logic [2:0]  mask;
        logic        rr;
        logic        rdy;
        logic        cen;
        logic        gwen;
        logic [58:0] wen;
        logic [7:0]  a;
        logic [58:0] d;
        logic        rv;
        logic [58:0] rd;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vt [NVEC];

    logic [58:0] zero = '0;
    logic [58:0] ones = '1;
    logic [58:0] w1   = 59'h5A5A5A5A5A5A5A5;
    logic [58:0] w9   = 59'h123456789ABCDEF;
    logic [58:0] v3;
    logic [7:0]  a0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic wr, input logic [7:0] addr,
                         input logic [58:0] wdata, input logic [2:0] mask, input logic rr);
        req_vld   = vld;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        rsp_rdy   = rr;
    endtask

    task automatic do_reset();
        int bad;
        @(negedge CLK);
        RST = 1'b1;
        drive(1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 8'h44, zero, 3'd0, 1'b1);
        #1;
        chk("rst req_rdy", 64'(req_rdy), 64'd0);
        chk("rst CEN", 64'(CEN), 64'd1);
        chk("rst GWEN", 64'(GWEN), 64'd1);
        chk("rst WEN", 64'(WEN), 64'(ones));
        chk("rst A", 64'(A), 64'd0);
        chk("rst D", 64'(D), 64'd0);
        chk("rst rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst init_done", 64'(init_done), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b0);
        #1;
        chk("rel init_done low", 64'(init_done), 64'd0);
`ifdef CT_SPSRAM_CTRL_INIT_EN
        drive(1'b1, 1'b1, 8'h55, ones, 3'd7, 1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            #1;
            if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== zero || D !== zero ||
                A !== 8'(i) || req_rdy !== 1'b0 || init_done !== 1'b0) begin
                bad++;
            end
        end
        chk("sweep bad cycles", 64'(bad), 64'd0);
        drive(1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b0);
        @(negedge CLK);
        #1;
        chk("sweep init_done", 64'(init_done), 64'd1);
        chk("sweep idle CEN", 64'(CEN), 64'd1);
`else
        bad = 0;
        @(negedge CLK);
        #1;
        chk("rel init_done high", 64'(init_done + bad), 64'd1);
        chk("rel CEN", 64'(CEN), 64'd1);
        chk("rel GWEN", 64'(GWEN), 64'd1);
        chk("rel WEN", 64'(WEN), 64'(ones));
`endif
        chk("rel rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rel req_rdy", 64'(req_rdy), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        v3 = {1'b1, 29'd0, {29{1'b1}}};
`ifdef CT_SPSRAM_CTRL_INIT_EN
        a0 = 8'hFF;
`else
        a0 = 8'h00;
`endif
        //        vld   wr    addr   wdata mask  rr  | rdy cen gwen wen a d rv rd
        vt[0]  = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, ones, a0, zero, 1'b0, zero};
        vt[1]  = '{1'b1, 1'b1, 8'h12, w1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, zero, 8'h12, w1, 1'b0, zero};
        vt[2]  = '{1'b1, 1'b0, 8'h12, zero, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, ones, 8'h12, zero, 1'b0, zero};
        vt[3]  = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, ones, 8'h12, zero, 1'b0, zero};
        vt[4]  = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, ones, 8'h12, zero, 1'b1, w1};
        vt[5]  = '{1'b1, 1'b1, 8'h03, ones, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, zero, 8'h03, ones, 1'b0, zero};
        vt[6]  = '{1'b1, 1'b1, 8'h03, zero, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, v3, 8'h03, zero, 1'b0, zero};
        vt[7]  = '{1'b1, 1'b0, 8'h03, zero, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, ones, 8'h03, zero, 1'b0, zero};
        vt[8]  = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, ones, 8'h03, zero, 1'b0, zero};
        vt[9]  = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, ones, 8'h03, zero, 1'b1, v3};
        vt[10] = '{1'b1, 1'b1, 8'h05, ones, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, ones, 8'h05, ones, 1'b0, zero};
        vt[11] = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, ones, 8'h05, zero, 1'b0, zero};
        // Reads with rsp_rdy low: two accepted, third blocked, write still fires.
        vt[12] = '{1'b1, 1'b0, 8'h12, zero, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, ones, 8'h12, zero, 1'b0, zero};
        vt[13] = '{1'b1, 1'b0, 8'h03, zero, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, ones, 8'h03, zero, 1'b0, zero};
        vt[14] = '{1'b1, 1'b0, 8'h05, zero, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, ones, 8'h03, zero, 1'b1, w1};
        vt[15] = '{1'b1, 1'b1, 8'h09, w9, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, zero, 8'h09, w9, 1'b1, w1};
        vt[16] = '{1'b1, 1'b0, 8'h05, zero, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, ones, 8'h09, zero, 1'b1, w1};
        vt[17] = '{1'b1, 1'b0, 8'h05, zero, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, ones, 8'h09, zero, 1'b1, w1};
        vt[18] = '{1'b1, 1'b0, 8'h05, zero, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, ones, 8'h05, zero, 1'b1, v3};
        vt[19] = '{1'b1, 1'b0, 8'h12, zero, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, ones, 8'h12, zero, 1'b0, zero};
        vt[20] = '{1'b1, 1'b0, 8'h09, zero, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, ones, 8'h12, zero, 1'b1, zero};
        vt[21] = '{1'b1, 1'b0, 8'h09, zero, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, ones, 8'h09, zero, 1'b1, w1};
        vt[22] = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, ones, 8'h09, zero, 1'b0, zero};
        vt[23] = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, ones, 8'h09, zero, 1'b1, w9};
        vt[24] = '{1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, ones, 8'h09, zero, 1'b0, zero};

        do_reset();

        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            drive(vt[i].vld, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].mask, vt[i].rr);
            #1;
            chk($sformatf("row%0d req_rdy", i), 64'(req_rdy), 64'(vt[i].rdy));
            chk($sformatf("row%0d CEN", i), 64'(CEN), 64'(vt[i].cen));
            chk($sformatf("row%0d GWEN", i), 64'(GWEN), 64'(vt[i].gwen));
            chk($sformatf("row%0d WEN", i), 64'(WEN), 64'(vt[i].wen));
            chk($sformatf("row%0d A", i), 64'(A), 64'(vt[i].a));
            chk($sformatf("row%0d D", i), 64'(D), 64'(vt[i].d));
            chk($sformatf("row%0d rsp_vld", i), 64'(rsp_vld), 64'(vt[i].rv));
            chk($sformatf("row%0d rsp_rdata", i), 64'(rsp_rdata), 64'(vt[i].rd));
        end

        // Reset the cycle after a read fires while the buffer holds one entry.
        @(negedge CLK);
        drive(1'b1, 1'b0, 8'h03, zero, 3'd0, 1'b0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 8'h12, zero, 3'd0, 1'b0);
        #1;
        chk("mid read rdy", 64'(req_rdy), 64'd1);
        chk("mid rsp_vld before rst", 64'(rsp_vld), 64'd1);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            drive(1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1);
            #1;
            chk($sformatf("post rst idle%0d rsp_vld", k), 64'(rsp_vld), 64'd0);
        end

        @(negedge CLK);
`ifdef CT_SPSRAM_CTRL_INIT_EN
        drive(1'b1, 1'b0, 8'd200, zero, 3'd0, 1'b1);
`else
        drive(1'b1, 1'b0, 8'h03, zero, 3'd0, 1'b1);
`endif
        #1;
        chk("post rst read rdy", 64'(req_rdy), 64'd1);
        chk("post rst read CEN", 64'(CEN), 64'd0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 8'h00, zero, 3'd0, 1'b1);
        #1;
        chk("post rst latency", 64'(rsp_vld), 64'd0);
        @(negedge CLK);
        #1;
        chk("post rst rsp_vld", 64'(rsp_vld), 64'd1);
`ifdef CT_SPSRAM_CTRL_INIT_EN
        chk("post rst rdata", 64'(rsp_rdata), 64'd0);
`else
        chk("post rst rdata", 64'(rsp_rdata), 64'(v3));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
